// File: rtl/adc_capture_ctrl.sv
// ADC sample capture controller: writes decimated samples into a DPRAM window,
// either once (one-shot) or as a ring that stops a programmable count after a trigger.
module adc_capture_ctrl #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 13,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 13'h400,
  parameter int                 DEPTH     = 4096,
  parameter int                 DECIM_W   = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] adc_sample_in,
  input  logic              adc_valid_i,
  input  logic              csr_start_i,
  input  logic              csr_mode_i,
  input  logic [DECIM_W-1:0] csr_decim_i,
  input  logic [ADDR_W:0]   csr_posttrig_i,
  input  logic              trig_i,
  output logic              csr_busy_o,
  output logic              csr_done_o,
  output logic              csr_wrap_o,
  output logic [ADDR_W-1:0] csr_trig_addr_o,
  output logic              adc_we_o,
  output logic [DATA_W-1:0] adc_data_o,
  output logic [ADDR_W-1:0] adc_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_ARM, S_POST, S_DONE} state_t;

  state_t              state, state_nx;
  logic [DECIM_W-1:0]  decim_q, decim_cnt;
  logic [ADDR_W:0]     post_q, post_cnt, post_next;
  logic [ADDR_W-1:0]   ptr, ptr_inc, trig_addr_q, addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q, wrap_q, we_q;
  logic                busy, hit, wr, trig_now, start_cap;

  assign busy      = (state == S_RUN) || (state == S_ARM) || (state == S_POST);
  assign hit       = adc_valid_i && (decim_cnt == decim_q);
  assign post_next = post_cnt + (ADDR_W + 1)'(1);
  assign ptr_inc   = (ptr == LAST_ADDR) ? BASE_ADDR : ptr + ADDR_W'(1);
  assign start_cap = (state == S_IDLE) && csr_start_i;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    trig_now = 1'b0;
    unique case (state)
      S_IDLE: if (csr_start_i) state_nx = csr_mode_i ? S_ARM : S_RUN;
      S_RUN: begin
        if (!csr_start_i) state_nx = S_IDLE;
        else if (hit) begin
          wr = 1'b1;
          if (ptr == LAST_ADDR) state_nx = S_DONE;
        end
      end
      S_ARM: begin
        if (!csr_start_i) state_nx = S_IDLE;
        else if (trig_i) begin
          trig_now = 1'b1;
          if (post_q == '0) state_nx = S_DONE;
          else begin
            wr       = hit;
            state_nx = (hit && post_q == (ADDR_W + 1)'(1)) ? S_DONE : S_POST;
          end
        end else wr = hit;
      end
      S_POST: begin
        if (!csr_start_i) state_nx = S_IDLE;
        else if (hit) begin
          wr = 1'b1;
          if (post_next == post_q) state_nx = S_DONE;
        end
      end
      S_DONE: if (!csr_start_i) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      decim_q     <= '0;
      decim_cnt   <= '0;
      post_q      <= '0;
      post_cnt    <= '0;
      ptr         <= BASE_ADDR;
      trig_addr_q <= BASE_ADDR;
      addr_q      <= BASE_ADDR;
      data_q      <= '0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state <= state_nx;
      we_q  <= wr;
      if (wr) begin
        data_q <= adc_sample_in;
        addr_q <= ptr;
        ptr    <= ptr_inc;
      end
      if (start_cap) begin
        decim_q     <= csr_decim_i;
        post_q      <= (csr_posttrig_i > DEPTH_CNT) ? DEPTH_CNT : csr_posttrig_i;
        decim_cnt   <= '0;
        post_cnt    <= '0;
        ptr         <= BASE_ADDR;
        trig_addr_q <= BASE_ADDR;
        done_q      <= 1'b0;
        wrap_q      <= 1'b0;
      end else if (busy && adc_valid_i) begin
        decim_cnt <= hit ? '0 : decim_cnt + DECIM_W'(1);
      end
      // The trigger-cycle sample, if accepted, is the first post-trigger write.
      if (trig_now) begin
        trig_addr_q <= ptr;
        post_cnt    <= wr ? (ADDR_W + 1)'(1) : '0;
      end else if (state == S_POST && wr) begin
        post_cnt <= post_next;
      end
      if (state == S_ARM && wr && ptr == LAST_ADDR) wrap_q <= 1'b1;
      if (state != S_DONE && state_nx == S_DONE) done_q <= 1'b1;
    end
  end

  assign csr_busy_o      = busy;
  assign csr_done_o      = done_q;
  assign csr_wrap_o      = wrap_q;
  assign csr_trig_addr_o = trig_addr_q;
  assign adc_we_o        = we_q;
  assign adc_data_o      = data_q;
  assign adc_addr_o      = addr_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: one-shot, decimation, ring capture,
// ring corner cases, abort/restart and asynchronous reset.
module tb_adc_capture_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 13;
  localparam int DECIM_W = 8;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [DATA_W-1:0]  adc_sample_in;
  logic               adc_valid_i;
  logic               csr_start_i;
  logic               csr_mode_i;
  logic [DECIM_W-1:0] csr_decim_i;
  logic [ADDR_W:0]    csr_posttrig_i;
  logic               trig_i;
  logic               csr_busy_o, csr_done_o, csr_wrap_o, adc_we_o;
  logic [ADDR_W-1:0]  csr_trig_addr_o, adc_addr_o;
  logic [DATA_W-1:0]  adc_data_o;

  int errors = 0;
  int checks = 0;

  adc_capture_ctrl dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .adc_sample_in   (adc_sample_in),
    .adc_valid_i     (adc_valid_i),
    .csr_start_i     (csr_start_i),
    .csr_mode_i      (csr_mode_i),
    .csr_decim_i     (csr_decim_i),
    .csr_posttrig_i  (csr_posttrig_i),
    .trig_i          (trig_i),
    .csr_busy_o      (csr_busy_o),
    .csr_done_o      (csr_done_o),
    .csr_wrap_o      (csr_wrap_o),
    .csr_trig_addr_o (csr_trig_addr_o),
    .adc_we_o        (adc_we_o),
    .adc_data_o      (adc_data_o),
    .adc_addr_o      (adc_addr_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock edge and settle, so outputs reflect that edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_cfg(input logic mode, input logic [DECIM_W-1:0] decim,
                           input logic [ADDR_W:0] post);
    csr_mode_i     = mode;
    csr_decim_i    = decim;
    csr_posttrig_i = post;
    adc_valid_i    = 1'b0;
    trig_i         = 1'b0;
    csr_start_i    = 1'b1;
    step();
  endtask

  task automatic stop();
    csr_start_i = 1'b0;
    adc_valid_i = 1'b0;
    trig_i      = 1'b0;
    step();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    adc_sample_in = '0; adc_valid_i = 0; csr_start_i = 0; csr_mode_i = 0;
    csr_decim_i = '0; csr_posttrig_i = '0; trig_i = 0;
    step(); step();
    checks++; if (adc_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", adc_we_o); end
    checks++; if (adc_data_o !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", adc_data_o); end
    checks++; if (adc_addr_o !== 13'h400) begin errors++; $display("FAIL reset_addr got=%0h exp=400", adc_addr_o); end
    checks++; if (csr_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", csr_busy_o); end
    checks++; if (csr_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", csr_done_o); end
    checks++; if (csr_wrap_o !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%0h exp=0", csr_wrap_o); end
    checks++; if (csr_trig_addr_o !== 13'h400) begin errors++; $display("FAIL reset_trig_addr got=%0h exp=400", csr_trig_addr_o); end
    #4 sys_rst = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    int bad = 0;
    int first_bad = -1;
    start_cfg(1'b0, '0, '0);
    checks++; if (csr_busy_o !== 1'b1) begin errors++; $display("FAIL oneshot_busy got=%0h exp=1", csr_busy_o); end
    adc_valid_i = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      adc_sample_in = 32'hA500_0000 + 32'(i);
      step();
      if (adc_we_o !== 1'b1 || adc_addr_o !== 13'(13'h400 + i) ||
          adc_data_o !== 32'hA500_0000 + 32'(i) || csr_done_o !== (i == 4095)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL oneshot_stream bad_cycles=%0d first_at=%0d exp 0 bad cycles", bad, first_bad); end
    checks++; if (csr_busy_o !== 1'b0) begin errors++; $display("FAIL oneshot_busy_fall got=%0h exp=0", csr_busy_o); end
    adc_sample_in = 32'hDEAD_BEEF;
    step();
    checks++; if (adc_we_o !== 1'b0) begin errors++; $display("FAIL oneshot_no_extra_write got=%0h exp=0 addr=%0h", adc_we_o, adc_addr_o); end
    stop();
    checks++; if (csr_done_o !== 1'b1 || csr_busy_o !== 1'b0) begin errors++; $display("FAIL oneshot_done_hold done=%0h busy=%0h exp done=1 busy=0", csr_done_o, csr_busy_o); end
  endtask

  task automatic test_decim();
    logic [31:0] exp_data [5] = '{32'd3, 32'd7, 32'd11, 32'd15, 32'd19};
    int          exp_cyc  [5] = '{3, 7, 11, 15, 22};
    logic [31:0] got_data [$];
    int          got_cyc  [$];
    logic [ADDR_W-1:0] got_addr [$];
    int vidx = 0;
    start_cfg(1'b0, 8'd3, '0);
    checks++; if (csr_done_o !== 1'b0) begin errors++; $display("FAIL decim_done_cleared got=%0h exp=0", csr_done_o); end
    for (int c = 0; c < 23; c++) begin
      adc_valid_i   = !(c >= 16 && c < 19);
      adc_sample_in = 32'(vidx);
      step();
      if (adc_valid_i) vidx++;
      if (adc_we_o) begin
        got_data.push_back(adc_data_o);
        got_addr.push_back(adc_addr_o);
        got_cyc.push_back(c);
      end
    end
    checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL decim_count got=%0d exp=5", got_data.size()); end
    for (int k = 0; k < 5 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== exp_data[k] || got_cyc[k] !== exp_cyc[k] || got_addr[k] !== 13'(13'h400 + k)) begin
        errors++;
        $display("FAIL decim_write%0d data=%0d cyc=%0d addr=%0h exp data=%0d cyc=%0d addr=%0h",
                 k, got_data[k], got_cyc[k], got_addr[k], exp_data[k], exp_cyc[k], 13'h400 + k);
      end
    end
    stop();
  endtask

  task automatic test_ring();
    int post_writes = 0;
    logic [ADDR_W-1:0] first_post_addr = '0, last_addr = '0;
    logic [31:0] last_data = '0;
    int i = 0;
    start_cfg(1'b1, '0, 14'd100);
    adc_valid_i = 1'b1;
    while (!csr_done_o && i < 6000) begin
      adc_sample_in = 32'(i);
      trig_i        = (i >= 5000);
      step();
      if (adc_we_o && i >= 5000) begin
        if (post_writes == 0) first_post_addr = adc_addr_o;
        post_writes++;
        last_addr = adc_addr_o;
        last_data = adc_data_o;
      end
      i++;
    end
    checks++; if (csr_done_o !== 1'b1) begin errors++; $display("FAIL ring_done_timeout got=%0h exp=1", csr_done_o); end
    checks++; if (csr_trig_addr_o !== 13'h788) begin errors++; $display("FAIL ring_trig_addr got=%0h exp=788", csr_trig_addr_o); end
    checks++; if (csr_wrap_o !== 1'b1) begin errors++; $display("FAIL ring_wrap got=%0h exp=1", csr_wrap_o); end
    checks++; if (post_writes !== 100) begin errors++; $display("FAIL ring_post_count got=%0d exp=100", post_writes); end
    checks++; if (first_post_addr !== 13'h788) begin errors++; $display("FAIL ring_first_post_addr got=%0h exp=788", first_post_addr); end
    checks++; if (last_addr !== 13'h7EB || last_data !== 32'd5099) begin errors++; $display("FAIL ring_last addr=%0h data=%0d exp addr=7eb data=5099", last_addr, last_data); end
    step();
    checks++; if (adc_we_o !== 1'b0) begin errors++; $display("FAIL ring_write_after_done got=%0h exp=0", adc_we_o); end
    stop();
  endtask

  task automatic test_ring_edges();
    int writes = 0;
    int i = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    // posttrig=0: trigger before any wrap, no write in the trigger cycle
    start_cfg(1'b1, '0, '0);
    adc_valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      adc_sample_in = 32'(k);
      step();
    end
    trig_i = 1'b1;
    adc_sample_in = 32'hFFFF_0000;
    step();
    checks++; if (adc_we_o !== 1'b0) begin errors++; $display("FAIL post0_write got=%0h exp=0", adc_we_o); end
    checks++; if (csr_done_o !== 1'b1 || csr_busy_o !== 1'b0) begin errors++; $display("FAIL post0_done done=%0h busy=%0h exp done=1 busy=0", csr_done_o, csr_busy_o); end
    checks++; if (csr_trig_addr_o !== 13'h40A) begin errors++; $display("FAIL post0_trig_addr got=%0h exp=40a", csr_trig_addr_o); end
    checks++; if (csr_wrap_o !== 1'b0) begin errors++; $display("FAIL post0_wrap got=%0h exp=0", csr_wrap_o); end
    stop();

    // posttrig=5000 clamps to a full window of post-trigger writes
    start_cfg(1'b1, '0, 14'd5000);
    adc_valid_i = 1'b1;
    while (!csr_done_o && i < 6000) begin
      adc_sample_in = 32'(i);
      trig_i        = (i >= 3);
      step();
      if (adc_we_o && i >= 3) begin
        writes++;
        last_addr = adc_addr_o;
      end
      i++;
    end
    checks++; if (writes !== 4096) begin errors++; $display("FAIL clamp_count got=%0d exp=4096", writes); end
    checks++; if (last_addr !== 13'h402) begin errors++; $display("FAIL clamp_last_addr got=%0h exp=402", last_addr); end
    checks++; if (csr_wrap_o !== 1'b0) begin errors++; $display("FAIL clamp_wrap got=%0h exp=0", csr_wrap_o); end
    checks++; if (csr_trig_addr_o !== 13'h403) begin errors++; $display("FAIL clamp_trig_addr got=%0h exp=403", csr_trig_addr_o); end
    stop();
  endtask

  task automatic test_abort_restart();
    int stray = 0;
    start_cfg(1'b0, '0, '0);
    adc_valid_i = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      adc_sample_in = 32'(i);
      step();
    end
    checks++; if (adc_we_o !== 1'b1 || adc_addr_o !== 13'h500) begin errors++; $display("FAIL abort_reach we=%0h addr=%0h exp we=1 addr=500", adc_we_o, adc_addr_o); end
    csr_start_i = 1'b0;
    step();
    checks++; if (adc_we_o !== 1'b0 || csr_busy_o !== 1'b0 || csr_done_o !== 1'b0) begin
      errors++; $display("FAIL abort_state we=%0h busy=%0h done=%0h exp all 0", adc_we_o, csr_busy_o, csr_done_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (adc_we_o) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort_stray_writes got=%0d exp=0", stray); end
    csr_start_i = 1'b1;
    adc_valid_i = 1'b0;
    step();
    adc_valid_i   = 1'b1;
    adc_sample_in = 32'h1234_5678;
    step();
    checks++; if (adc_we_o !== 1'b1 || adc_addr_o !== 13'h400 || adc_data_o !== 32'h1234_5678) begin
      errors++; $display("FAIL restart_first we=%0h addr=%0h data=%0h exp we=1 addr=400 data=12345678", adc_we_o, adc_addr_o, adc_data_o); end
    stop();
  endtask

  task automatic test_async_reset();
    start_cfg(1'b1, '0, 14'd100);
    adc_valid_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      adc_sample_in = 32'h5500_0000 + 32'(i);
      trig_i        = (i >= 5);
      step();
    end
    checks++; if (adc_we_o !== 1'b1 || csr_trig_addr_o !== 13'h405) begin
      errors++; $display("FAIL areset_pre we=%0h trig_addr=%0h exp we=1 trig_addr=405", adc_we_o, csr_trig_addr_o); end
    #2 sys_rst = 1'b1;
    #1;
    checks++; if (adc_we_o !== 1'b0 || adc_data_o !== '0 || adc_addr_o !== 13'h400) begin
      errors++; $display("FAIL areset_write we=%0h data=%0h addr=%0h exp we=0 data=0 addr=400", adc_we_o, adc_data_o, adc_addr_o); end
    checks++; if (csr_busy_o !== 1'b0 || csr_done_o !== 1'b0 || csr_wrap_o !== 1'b0 || csr_trig_addr_o !== 13'h400) begin
      errors++; $display("FAIL areset_csr busy=%0h done=%0h wrap=%0h trig_addr=%0h exp 0 0 0 400",
                         csr_busy_o, csr_done_o, csr_wrap_o, csr_trig_addr_o); end
    csr_start_i = 1'b0; adc_valid_i = 1'b0; trig_i = 1'b0;
    step();
    #3 sys_rst = 1'b0;
    step();
    start_cfg(1'b0, '0, '0);
    checks++; if (csr_busy_o !== 1'b1) begin errors++; $display("FAIL areset_restart_busy got=%0h exp=1", csr_busy_o); end
    adc_valid_i   = 1'b1;
    adc_sample_in = 32'hCAFE_0001;
    step();
    checks++; if (adc_we_o !== 1'b1 || adc_addr_o !== 13'h400 || adc_data_o !== 32'hCAFE_0001) begin
      errors++; $display("FAIL areset_restart_write we=%0h addr=%0h data=%0h exp we=1 addr=400 data=cafe0001", adc_we_o, adc_addr_o, adc_data_o); end
    stop();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_decim();
    test_ring();
    test_ring_edges();
    test_abort_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
